// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller: ALUOP encodings,
// opcode values, FSM states and the decoded-instruction record.
package alu_pkg;

   localparam int BW  = 64;
   localparam int OPW = 3;

   localparam logic [OPW-1:0] ALU_ADD = 3'b000;
   localparam logic [OPW-1:0] ALU_SUB = 3'b001;
   localparam logic [OPW-1:0] ALU_AND = 3'b010;
   localparam logic [OPW-1:0] ALU_OR  = 3'b011;
   localparam logic [OPW-1:0] ALU_XOR = 3'b100;
   localparam logic [OPW-1:0] ALU_SLL = 3'b101;
   localparam logic [OPW-1:0] ALU_SRL = 3'b110;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LTU, BR_GEU} br_kind_t;

   typedef struct packed {
      logic [OPW-1:0] op;
      logic [BW-1:0]  a;
      logic [BW-1:0]  b;
      logic           is_br;
      br_kind_t       br_kind;
      logic           illegal;
   } dec_t;

   // Shift amount is confined to 0..63 regardless of the source value.
   function automatic logic [BW-1:0] shamt(input logic [BW-1:0] src);
      return {{(BW-6){1'b0}}, src[5:0]};
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in, ALU and response bundle of the ALU issue controller.
// slave = the controller's view, master = the surrounding execute stage.
interface alu_issue_ctrl_if;
   import alu_pkg::*;

   logic           in_valid;
   logic           in_ready;
   logic [6:0]     opcode;
   logic [2:0]     funct3;
   logic           funct7_b5;
   logic [BW-1:0]  rs1_val;
   logic [BW-1:0]  rs2_val;
   logic [BW-1:0]  imm;
   logic [BW-1:0]  alu_a;
   logic [BW-1:0]  alu_b;
   logic [OPW-1:0] alu_op;
   logic [BW-1:0]  alu_res;
   logic           alu_zf;
   logic           alu_cf;
   logic           out_valid;
   logic           out_ready;
   logic [BW-1:0]  out_res;
   logic           out_zf;
   logic           out_cf;
   logic           out_taken;
   logic           out_illegal;

   modport slave (
      input  in_valid, opcode, funct3, funct7_b5, rs1_val, rs2_val, imm,
      input  alu_res, alu_zf, alu_cf, out_ready,
      output in_ready, alu_a, alu_b, alu_op,
      output out_valid, out_res, out_zf, out_cf, out_taken, out_illegal
   );

   modport master (
      output in_valid, opcode, funct3, funct7_b5, rs1_val, rs2_val, imm,
      output alu_res, alu_zf, alu_cf, out_ready,
      input  in_ready, alu_a, alu_b, alu_op,
      input  out_valid, out_res, out_zf, out_cf, out_taken, out_illegal
   );

endinterface

// File: rtl/alu64.sv
// Combinational 64-bit ALU driven by alu_issue_ctrl; cf is carry on ADD and
// borrow (A < B unsigned) on SUB, zero otherwise.
module alu64
   import alu_pkg::*;
(
   input  logic [BW-1:0]  a,
   input  logic [BW-1:0]  b,
   input  logic [OPW-1:0] op,
   output logic [BW-1:0]  res,
   output logic           zf,
   output logic           cf
);

   logic [BW:0] sum;
   logic [BW:0] diff;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      res  = '0;
      cf   = 1'b0;
      case (op)
         ALU_ADD: {cf, res} = sum;
         ALU_SUB: {cf, res} = diff;
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_XOR: res = a ^ b;
         ALU_SLL: res = a << b[5:0];
         ALU_SRL: res = a >> b[5:0];
         default: res = '0;
      endcase
   end

   assign zf = (res == '0);

endmodule

// File: rtl/alu_issue_decode.sv
// Combinational decode of R/I/branch fields into ALUOP, operands and branch kind.
// Build option ALU_ISSUE_BLTU_EN adds the unsigned branches BLTU/BGEU.
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [6:0]    opcode,
   input  logic [2:0]    funct3,
   input  logic          funct7_b5,
   input  logic [BW-1:0] rs1_val,
   input  logic [BW-1:0] rs2_val,
   input  logic [BW-1:0] imm,
   output dec_t          dec
);

   logic [BW-1:0] src2;

   always_comb begin
      src2        = (opcode == OP_R) ? rs2_val : imm;
      dec.op      = ALU_ADD;
      dec.a       = rs1_val;
      dec.b       = src2;
      dec.is_br   = 1'b0;
      dec.br_kind = BR_EQ;
      dec.illegal = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            case (funct3)
               3'b000: dec.op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
               3'b111: dec.op = ALU_AND;
               3'b110: dec.op = ALU_OR;
               3'b100: dec.op = ALU_XOR;
               3'b001: begin
                  dec.op = ALU_SLL;
                  dec.b  = shamt(src2);
               end
               3'b101: begin
                  dec.op      = ALU_SRL;
                  dec.b       = shamt(src2);
                  dec.illegal = funct7_b5;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_BR: begin
            dec.op    = ALU_SUB;
            dec.b     = rs2_val;
            dec.is_br = 1'b1;
            case (funct3)
               3'b000: dec.br_kind = BR_EQ;
               3'b001: dec.br_kind = BR_NE;
`ifdef ALU_ISSUE_BLTU_EN
               3'b110: dec.br_kind = BR_LTU;
               3'b111: dec.br_kind = BR_GEU;
`endif
               default: dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase
      // Unsupported encodings still issue a harmless 0+0 so the ALU never sees junk.
      if (dec.illegal) begin
         dec.op      = ALU_ADD;
         dec.a       = '0;
         dec.b       = '0;
         dec.is_br   = 1'b0;
         dec.br_kind = BR_EQ;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues decoded ops to the external ALU, captures result/flags one cycle later
// and returns them over a valid/ready handshake. Option: ALU_ISSUE_BLTU_EN.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   alu_issue_ctrl_if.slave  bus
);

   state_t         state_reg, state_next;
   dec_t           dec;
   logic [BW-1:0]  alu_a_reg, alu_b_reg, out_res_reg;
   logic [OPW-1:0] alu_op_reg;
   logic           is_br_reg, illegal_reg;
   br_kind_t       br_kind_reg;
   logic           out_zf_reg, out_cf_reg, out_taken_reg, out_illegal_reg;
   logic           in_ready_next, out_valid_next, taken_next, accept;

   alu_issue_decode u_decode (
      .opcode    (bus.opcode),
      .funct3    (bus.funct3),
      .funct7_b5 (bus.funct7_b5),
      .rs1_val   (bus.rs1_val),
      .rs2_val   (bus.rs2_val),
      .imm       (bus.imm),
      .dec       (dec)
   );

   always_comb begin
      state_next     = state_reg;
      in_ready_next  = 1'b0;
      out_valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready_next = 1'b1;
            if (bus.in_valid) state_next = EXEC;
         end
         EXEC: state_next = RESP;
         RESP: begin
            out_valid_next = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = (state_reg == IDLE) && bus.in_valid;

   always_comb begin
      taken_next = 1'b0;
      if (is_br_reg && !illegal_reg) begin
         case (br_kind_reg)
            BR_EQ:  taken_next = bus.alu_zf;
            BR_NE:  taken_next = ~bus.alu_zf;
            BR_LTU: taken_next = bus.alu_cf;
            BR_GEU: taken_next = ~bus.alu_cf;
            default: taken_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         alu_a_reg       <= '0;
         alu_b_reg       <= '0;
         alu_op_reg      <= ALU_ADD;
         is_br_reg       <= 1'b0;
         br_kind_reg     <= BR_EQ;
         illegal_reg     <= 1'b0;
         out_res_reg     <= '0;
         out_zf_reg      <= 1'b0;
         out_cf_reg      <= 1'b0;
         out_taken_reg   <= 1'b0;
         out_illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            alu_a_reg   <= dec.a;
            alu_b_reg   <= dec.b;
            alu_op_reg  <= dec.op;
            is_br_reg   <= dec.is_br;
            br_kind_reg <= dec.br_kind;
            illegal_reg <= dec.illegal;
         end
         // Illegal ops report all-zero result and flags, not what 0+0 produced.
         if (state_reg == EXEC) begin
            out_res_reg     <= illegal_reg ? '0 : bus.alu_res;
            out_zf_reg      <= illegal_reg ? 1'b0 : bus.alu_zf;
            out_cf_reg      <= illegal_reg ? 1'b0 : bus.alu_cf;
            out_taken_reg   <= taken_next;
            out_illegal_reg <= illegal_reg;
         end
      end
   end

   assign bus.in_ready    = in_ready_next;
   assign bus.out_valid   = out_valid_next;
   assign bus.alu_a       = alu_a_reg;
   assign bus.alu_b       = alu_b_reg;
   assign bus.alu_op      = alu_op_reg;
   assign bus.out_res     = out_res_reg;
   assign bus.out_zf      = out_zf_reg;
   assign bus.out_cf      = out_cf_reg;
   assign bus.out_taken   = out_taken_reg;
   assign bus.out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with the ALU beside it; expected responses
// are queued at issue time and compared when out_valid appears.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        zf;
      logic        cf;
      logic        taken;
      logic        illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_issue_ctrl_if bus();

   alu_issue_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   alu64 u_alu (
      .a   (bus.alu_a),
      .b   (bus.alu_b),
      .op  (bus.alu_op),
      .res (bus.alu_res),
      .zf  (bus.alu_zf),
      .cf  (bus.alu_cf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] res, input logic zf, input logic cf,
                               input logic taken, input logic illegal);
      exp_t e;
      e.op = op; e.a = a; e.b = b; e.res = res;
      e.zf = zf; e.cf = cf; e.taken = taken; e.illegal = illegal;
      return e;
   endfunction

   task automatic cmp_out(input string name, input exp_t x);
      chk({name, ".out_res"}, bus.out_res, x.res);
      chk({name, ".out_zf"}, {63'd0, bus.out_zf}, {63'd0, x.zf});
      chk({name, ".out_cf"}, {63'd0, bus.out_cf}, {63'd0, x.cf});
      chk({name, ".out_taken"}, {63'd0, bus.out_taken}, {63'd0, x.taken});
      chk({name, ".out_illegal"}, {63'd0, bus.out_illegal}, {63'd0, x.illegal});
   endtask

   task automatic run_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic b5, input logic [63:0] r1, input logic [63:0] r2,
                         input logic [63:0] im, input exp_t e, input int hold);
      exp_t x;
      int   cnt;
      bus.opcode = opc; bus.funct3 = f3; bus.funct7_b5 = b5;
      bus.rs1_val = r1; bus.rs2_val = r2; bus.imm = im;
      bus.in_valid = 1'b1;
      sb.push_back(e);
      chk({name, ".in_ready"}, {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({name, ".alu_op"}, {61'd0, bus.alu_op}, {61'd0, e.op});
      chk({name, ".alu_a"}, bus.alu_a, e.a);
      chk({name, ".alu_b"}, bus.alu_b, e.b);
      chk({name, ".exec_valid"}, {63'd0, bus.out_valid}, 64'd0);
      cnt = 0;
      while (bus.out_valid !== 1'b1 && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({name, ".latency"}, 64'(cnt), 64'd1);
      x = sb.pop_front();
      cmp_out(name, x);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.opcode = OP_R; bus.funct3 = 3'b100; bus.rs1_val = 64'hDEAD;
         @(posedge clk); #1;
         chk({name, ".hold_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
         chk({name, ".hold_valid"}, {63'd0, bus.out_valid}, 64'd1);
         cmp_out({name, ".hold"}, x);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk({name, ".done_valid"}, {63'd0, bus.out_valid}, 64'd0);
      chk({name, ".done_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
      $display("op %s res=0x%0h zf=%0b cf=%0b taken=%0b illegal=%0b", name,
               bus.out_res, bus.out_zf, bus.out_cf, bus.out_taken, bus.out_illegal);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.opcode = '0; bus.funct3 = '0; bus.funct7_b5 = 1'b0;
      bus.rs1_val = '0; bus.rs2_val = '0; bus.imm = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst.alu_a", bus.alu_a, 64'd0);
      chk("rst.alu_b", bus.alu_b, 64'd0);
      chk("rst.alu_op", {61'd0, bus.alu_op}, 64'd0);
      chk("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst.out_res", bus.out_res, 64'd0);
      chk("rst.out_flags", {60'd0, bus.out_zf, bus.out_cf, bus.out_taken, bus.out_illegal}, 64'd0);
      $display("op reset out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);

      run_op("add", 7'b0110011, 3'b000, 1'b0, 64'd7, 64'd15, 64'd0,
             mk(3'b000, 64'd7, 64'd15, 64'd22, 1'b0, 1'b0, 1'b0, 1'b0), 5);
      run_op("sub", 7'b0110011, 3'b000, 1'b1, 64'd5, 64'd5, 64'd0,
             mk(3'b001, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0), 0);
      run_op("beq", 7'b1100011, 3'b000, 1'b0, 64'd5, 64'd5, 64'd0,
             mk(3'b001, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0), 0);
      run_op("bne", 7'b1100011, 3'b001, 1'b0, 64'd5, 64'd5, 64'd0,
             mk(3'b001, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0), 0);
      run_op("slli", 7'b0010011, 3'b001, 1'b0, 64'd3, 64'd0, 64'h41,
             mk(3'b101, 64'd3, 64'd1, 64'd6, 1'b0, 1'b0, 1'b0, 1'b0), 0);
      run_op("srai", 7'b0010011, 3'b101, 1'b1, 64'd3, 64'd0, 64'h2,
             mk(3'b000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);
      run_op("addi_b5", 7'b0010011, 3'b000, 1'b1, 64'd10, 64'd99, 64'd4,
             mk(3'b000, 64'd10, 64'd4, 64'd14, 1'b0, 1'b0, 1'b0, 1'b0), 0);
      run_op("add_carry", 7'b0110011, 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
             mk(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0), 0);
      run_op("andi", 7'b0010011, 3'b111, 1'b0, 64'hF0, 64'd0, 64'h3C,
             mk(3'b010, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 1'b0, 1'b0), 0);
      run_op("ori", 7'b0010011, 3'b110, 1'b0, 64'hF0, 64'd0, 64'h0F,
             mk(3'b011, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0), 0);
      run_op("xor", 7'b0110011, 3'b100, 1'b0, 64'hFF, 64'h0F, 64'd0,
             mk(3'b100, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
      run_op("srl", 7'b0110011, 3'b101, 1'b0, 64'h100, 64'h104, 64'd0,
             mk(3'b110, 64'h100, 64'd4, 64'h10, 1'b0, 1'b0, 1'b0, 1'b0), 0);
      run_op("bad_opc", 7'b0110111, 3'b000, 1'b0, 64'd8, 64'd8, 64'd8,
             mk(3'b000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);

      // reset pulsed while an op is in EXEC: that op must never respond
      bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_b5 = 1'b0;
      bus.rs1_val = 64'd100; bus.rs2_val = 64'd200; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_exec.out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_exec.in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_exec.alu_a", bus.alu_a, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_exec.quiet", {63'd0, bus.out_valid}, 64'd0);
      end
      $display("op rst_in_exec out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);

      run_op("add_after_rst", 7'b0110011, 3'b000, 1'b0, 64'd1, 64'd2, 64'd0,
             mk(3'b000, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0), 0);

`ifdef ALU_ISSUE_BLTU_EN
      run_op("bltu", 7'b1100011, 3'b110, 1'b0, 64'd2, 64'd9, 64'd0,
             mk(3'b001, 64'd2, 64'd9, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 1'b1, 1'b0), 0);
      run_op("bgeu", 7'b1100011, 3'b111, 1'b0, 64'd9, 64'd2, 64'd0,
             mk(3'b001, 64'd9, 64'd2, 64'd7, 1'b0, 1'b0, 1'b1, 1'b0), 0);
`else
      run_op("bltu", 7'b1100011, 3'b110, 1'b0, 64'd2, 64'd9, 64'd0,
             mk(3'b000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);
      run_op("bgeu", 7'b1100011, 3'b111, 1'b0, 64'd9, 64'd2, 64'd0,
             mk(3'b000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);
`endif

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
